network_stream_source: RTL and testbench
========================================

Name: network_stream_source

Overview:
Transmit-side feeder for the layer network's streaming input. A loader writes one frame of N signed T-bit words into an internal register buffer. On `start`, the block drives the frame word-by-word onto a valid/ready master interface that connects directly to the network's s_valid/s_ready/data_in. It is the sending end of the same handshake the network receives on, and is used at the top level and in benches to replay test vectors under backpressure.

Parameters:
T, 16, word width in bits (signed)
N, 8, words per frame; N >= 2
AW, $clog2(N), pointer width (localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
ld_valid  input  1  loader word valid
ld_data  input  T  loader word, signed
ld_ready  output  1  buffer accepting loader words
start  input  1  one-cycle request to transmit the stored frame
m_valid  output  1  data_out valid toward network (network s_valid)
m_ready  input  1  network ready (network s_ready)
data_out  output  T  signed word toward network (network data_in)
busy  output  1  high while in SEND
done  output  1  one-cycle pulse after last word handshakes

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge of clk.
- On reset: state=LOAD, wr_ptr=0, rd_ptr=0, done=0. Buffer contents are don't-care. After the reset edge: ld_ready=1, m_valid=0, busy=0.
- ld_ready, m_valid and busy are Moore outputs decoded from state. done is registered.
- State LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready: mem[wr_ptr]<=ld_data; wr_ptr++.
  - Write with wr_ptr==N-1: wr_ptr<=0, go to FULL.
  - start is ignored.
- State FULL:
  - ld_ready=0; loader words are not accepted.
  - start=1: go to SEND, rd_ptr<=0.
- State SEND:
  - m_valid=1, busy=1, data_out=mem[rd_ptr].
  - On m_valid&&m_ready: rd_ptr++.
  - Handshake with rd_ptr==N-1: rd_ptr<=0, done<=1 for one cycle, go to LOAD.
  - start is ignored.
- Handshake rules:
  - Once m_valid rises, it stays high and data_out stays stable until the handshake.
  - m_valid never depends combinationally on m_ready.
  - m_ready may toggle freely. With m_ready held high, throughput is one word per cycle, i.e. N consecutive cycles of m_valid.
- Latency:
  - start sampled at edge k → m_valid=1 with word 0 in cycle k+1.
  - Last handshake at edge j → done=1 and m_valid=0 in cycle j+1; ld_ready=1 in that same cycle.
- data_out when m_valid=0: holds mem[rd_ptr]. Benches must not check it.
- Width rule: words pass through bit-exact. No sign extension, truncation or arithmetic.
- Reset mid-operation (any state): returns to LOAD on that edge and the frame is discarded. If reset occurs mid-SEND, m_valid drops in the next cycle and no done pulse is produced.
- Simultaneous events:
  - start together with the final load write: start is ignored, since the state is still LOAD.
  - reset with any other input: reset wins.

Optional Feature:
Macro NETWORK_STREAM_SOURCE_REPLAY_EN.
- Defined:
  - Adds input port `reload` (1 bit).
  - After the last SEND handshake, the state goes to FULL instead of LOAD, so the same frame can be resent by another start.
  - reload=1 in FULL: go to LOAD with wr_ptr=0.
  - reload is ignored in LOAD and SEND.
  - The done pulse is unchanged.
- Not defined: no reload port; the block always returns to LOAD after a frame.

Test Plan:
- Reset then load, N=4, T=16: write 16'sh0001, 16'shFFFF, 16'sh7FFF, 16'sh8000 with ld_valid held high → ld_ready=1 for 4 cycles, then 0. start → exactly those 4 words emitted in order over 4 cycles with m_ready=1; done pulses once; ld_ready returns to 1.
- Backpressure: m_ready pattern 1,0,0,1,0,1,1 during SEND → data_out is stable and m_valid stays high on every m_ready=0 cycle. Exactly 4 handshakes occur, with no duplicates or drops.
- Ignored start: start pulsed in LOAD after 2 writes → no m_valid. ld_valid pulsed in FULL → no write; the later frame equals the first 4 words written.
- Reset mid-SEND after 2 handshakes → m_valid=0 and ld_ready=1 next cycle, no done pulse. A fresh load of 4 words plus start emits only the new words.
- Back-to-back frames: load A (10,20,30,40), send, load B (-1,-2,-3,-4), send → output stream is 10,20,30,40,-1,-2,-3,-4, with two done pulses.
- With NETWORK_STREAM_SOURCE_REPLAY_EN: send frame, then start again → same 4 words re-emitted with no loader activity. reload → ld_ready=1 and a new frame is accepted.

Source files
------------

// File: rtl/network_stream_source.sv
`default_nettype none
//==============================================================================
// Module      : network_stream_source
// Description : Transmit-side frame feeder for the layer network's streaming
//               input. A loader fills an N-word register buffer. A start
//               request then replays the frame over a valid/ready master
//               interface that connects directly to the network's
//               s_valid / s_ready / data_in.
//
// Ports       : clk       - clock, rising edge
//               reset     - synchronous, active-high
//               ld_valid  - loader word valid
//               ld_data   - loader word (signed, T bits)
//               ld_ready  - buffer is accepting loader words (state LOAD)
//               start     - one-cycle request to transmit the stored frame
//               reload    - (replay build only) return from FULL to LOAD
//               m_valid   - word valid toward network (state SEND)
//               m_ready   - network ready
//               data_out  - word toward network (signed, T bits)
//               busy      - high while sending
//               done      - one-cycle pulse after the last word handshakes
//
// Options     : NETWORK_STREAM_SOURCE_REPLAY_EN - when defined, adds the
//               reload port. After a frame is sent the block parks in FULL,
//               so the same frame can be resent with another start.
//
// Revision    : 1.0 - initial release
//==============================================================================
module network_stream_source #(
    parameter int T = 16,
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic signed [T-1:0] ld_data,
    output logic                ld_ready,
    input  logic                start,
`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
    input  logic                reload,
`endif
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [T-1:0] data_out,
    output logic                busy,
    output logic                done
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] c_last = AW'(N - 1);
    localparam logic [AW-1:0] c_one  = AW'(1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FULL = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  r_done;
    logic signed [T-1:0]   r_mem [N];

    logic                  w_wr_en;
    logic                  w_hs;

    // Moore outputs decoded straight from the state register, so m_valid
    // never has a combinational path from m_ready.
    assign ld_ready = (r_state == S_LOAD);
    assign m_valid  = (r_state == S_SEND);
    assign busy     = (r_state == S_SEND);
    assign done     = r_done;
    assign data_out = r_mem[r_rd_ptr];

    assign w_wr_en  = (r_state == S_LOAD) && ld_valid && !reset;
    assign w_hs     = (r_state == S_SEND) && m_ready;

    // Frame buffer has no reset: its contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // start is deliberately not looked at here, even on the
                    // cycle of the final write.
                    if (ld_valid) begin
                        if (r_wr_ptr == c_last) begin
                            r_wr_ptr <= '0;
                            r_state  <= S_FULL;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_one;
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        r_rd_ptr <= '0;
                        r_state  <= S_SEND;
                    end
`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
                    else if (reload) begin
                        r_wr_ptr <= '0;
                        r_state  <= S_LOAD;
                    end
`endif
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_rd_ptr == c_last) begin
                            r_rd_ptr <= '0;
                            r_done   <= 1'b1;
`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
                            r_state  <= S_FULL;
`else
                            r_state  <= S_LOAD;
`endif
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_one;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_network_stream_source.sv
`default_nettype none
//==============================================================================
// Module      : tb_network_stream_source
// Description : Self-checking bench for network_stream_source (N=4, T=16).
//               A cycle table covers load, ignored start/load, streaming and
//               backpressure. Hand-written sequences cover reset mid-send,
//               back-to-back frames and, in the replay build, frame replay.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_network_stream_source;

    localparam int T = 16;
    localparam int N = 4;
`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
    localparam logic REPLAY = 1'b1;
    logic reload;
`else
    localparam logic REPLAY = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                ld_valid;
    logic signed [T-1:0] ld_data;
    logic                ld_ready;
    logic                start;
    logic                m_valid;
    logic                m_ready;
    logic signed [T-1:0] data_out;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    network_stream_source #(.T(T), .N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .start    (start),
`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
        .reload   (reload),
`endif
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One row = inputs held for one cycle + outputs expected in that cycle.
    typedef struct {
        logic        lv;
        logic [15:0] ld;
        logic        st;
        logic        mr;
        logic        rl;
        logic        e_ldr;
        logic        e_mv;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic lv, input logic [15:0] ld, input logic st,
                       input logic mr, input logic rl, input logic e_ldr,
                       input logic e_mv, input logic e_busy, input logic e_done,
                       input logic [15:0] e_data);
        vec_t v;
        v.lv = lv; v.ld = ld; v.st = st; v.mr = mr; v.rl = rl;
        v.e_ldr = e_ldr; v.e_mv = e_mv; v.e_busy = e_busy;
        v.e_done = e_done; v.e_data = e_data;
        tbl.push_back(v);
    endtask

    logic [15:0] stream[$];
    int          n_done;

    task automatic set_reload(input logic v);
`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
        reload = v;
`endif
    endtask

    task automatic load_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = w[i];
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    // Pulse start and collect handshaken words for a bounded window.
    task automatic send_frame();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            if (m_valid && m_ready) stream.push_back(data_out);
            @(negedge clk);
        end
        m_ready = 1'b0;
    endtask

    task automatic return_to_load();
        if (REPLAY) begin
            set_reload(1'b1);
            @(negedge clk);
            set_reload(1'b0);
        end
    endtask

    task automatic check_stream(input string name, input int base,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s word%0d", name, i), stream[base + i], e[i]);
        end
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0; m_ready = 1'b0;
        set_reload(1'b0);
        stream.delete();
        n_done = 0;

        //   lv  ld        st mr rl   ldr       mv busy done data
        add(1, 16'h0001, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);   // reset state
        add(1, 16'hFFFF, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);
        add(1, 16'h7FFF, 1, 0, 0,   1'b1,     0, 0, 0, 16'h0);   // start in LOAD
        add(1, 16'h8000, 1, 0, 0,   1'b1,     0, 0, 0, 16'h0);   // start on last write
        add(1, 16'h1234, 0, 0, 0,   1'b0,     0, 0, 0, 16'h0);   // write in FULL ignored
        add(1, 16'h5555, 1, 0, 0,   1'b0,     0, 0, 0, 16'h0);   // start accepted
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h0001);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'hFFFF);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h7FFF);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h8000);
        add(0, 16'h0000, 0, 1, 1,   !REPLAY,  0, 0, 1, 16'h0);   // done pulse
        add(0, 16'h0000, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);
        add(1, 16'h0011, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);
        add(1, 16'h0022, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);
        add(1, 16'h0033, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);
        add(1, 16'h0044, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);
        add(0, 16'h0000, 1, 0, 0,   1'b0,     0, 0, 0, 16'h0);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h0011); // ready 1,0,0,1,0,1,1
        add(0, 16'h0000, 0, 0, 0,   1'b0,     1, 1, 0, 16'h0022);
        add(0, 16'h0000, 0, 0, 0,   1'b0,     1, 1, 0, 16'h0022);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h0022);
        add(0, 16'h0000, 0, 0, 0,   1'b0,     1, 1, 0, 16'h0033);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h0033);
        add(0, 16'h0000, 0, 1, 0,   1'b0,     1, 1, 0, 16'h0044);
        add(0, 16'h0000, 0, 0, 1,   !REPLAY,  0, 0, 1, 16'h0);
        add(0, 16'h0000, 0, 0, 0,   1'b1,     0, 0, 0, 16'h0);

        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            ld_valid = tbl[i].lv;
            ld_data  = tbl[i].ld;
            start    = tbl[i].st;
            m_ready  = tbl[i].mr;
            set_reload(tbl[i].rl);
            check($sformatf("row%0d ld_ready", i), {31'b0, ld_ready}, {31'b0, tbl[i].e_ldr});
            check($sformatf("row%0d m_valid", i),  {31'b0, m_valid},  {31'b0, tbl[i].e_mv});
            check($sformatf("row%0d busy", i),     {31'b0, busy},     {31'b0, tbl[i].e_busy});
            check($sformatf("row%0d done", i),     {31'b0, done},     {31'b0, tbl[i].e_done});
            if (tbl[i].e_mv) begin
                check($sformatf("row%0d data_out", i), {16'b0, data_out}, {16'b0, tbl[i].e_data});
            end
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_data = '0; start = 1'b0; m_ready = 1'b0;
        set_reload(1'b0);

        // Reset during SEND after two handshakes.
        load_frame(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b1;
        check("midrst w0", {16'b0, data_out}, 32'h00A1);
        @(negedge clk);
        check("midrst w1", {16'b0, data_out}, 32'h00A2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        m_ready = 1'b0;
        check("midrst m_valid", {31'b0, m_valid}, 32'h0);
        check("midrst ld_ready", {31'b0, ld_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("midrst done c%0d", c), {31'b0, done}, 32'h0);
            @(negedge clk);
        end
        stream.delete();
        n_done = 0;
        load_frame(16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4);
        send_frame();
        check("midrst words", stream.size(), 32'd4);
        check_stream("midrst new", 0, 16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4);
        check("midrst dones", n_done, 32'd1);
        return_to_load();

        // Back-to-back frames.
        stream.delete();
        n_done = 0;
        load_frame(16'd10, 16'd20, 16'd30, 16'd40);
        send_frame();
        return_to_load();
        load_frame(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC);
        send_frame();
        return_to_load();
        check("b2b words", stream.size(), 32'd8);
        check_stream("b2b A", 0, 16'd10, 16'd20, 16'd30, 16'd40);
        check_stream("b2b B", 4, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC);
        check("b2b dones", n_done, 32'd2);

`ifdef NETWORK_STREAM_SOURCE_REPLAY_EN
        stream.delete();
        n_done = 0;
        load_frame(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04);
        send_frame();
        check("replay parked ld_ready", {31'b0, ld_ready}, 32'h0);
        send_frame();
        check("replay words", stream.size(), 32'd8);
        check_stream("replay 1st", 0, 16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04);
        check_stream("replay 2nd", 4, 16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04);
        check("replay dones", n_done, 32'd2);
        return_to_load();
        check("reload ld_ready", {31'b0, ld_ready}, 32'h1);
        stream.delete();
        load_frame(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04);
        send_frame();
        check("reload words", stream.size(), 32'd4);
        check_stream("reload new", 0, 16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
